trigger_issue_stage: RTL and testbench

Registered issue stage directly downstream of the trigger-resolution priority encoder in each PE. It consumes the resolved (valid, index) pair and holds the chosen instruction in an output register with a valid/ready handshake to the datapath. It also interlocks issue while an issued instruction's predicate write is still in flight, so the encoder never resolves triggers against stale predicate state. It returns a one-cycle acceptance strobe to the trigger/channel logic.

---
 rtl/trigger_issue_stage_pkg.sv | 16 +
 rtl/trigger_issue_saturating_counter.sv | 33 +++
 rtl/trigger_issue_stage.sv | 139 +++++++++++++
 tb/tb_trigger_issue_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_issue_stage_pkg.sv
// rtl/trigger_issue_stage_pkg.sv - shared types and constants for the trigger issue stage
// Contents: issue_state_t interlock states, default index width, default predicate
// update latency and the drain counter width (wide enough for latencies 0..15).
package trigger_issue_stage_pkg;

   localparam int unsigned TIA_INSTRUCTION_INDEX_WIDTH  = 5;
   localparam int unsigned TIA_PREDICATE_UPDATE_LATENCY = 2;
   localparam int unsigned TIA_DRAIN_COUNT_WIDTH        = 4;

   typedef enum logic [1:0] {
      ISSUE_IDLE  = 2'd0,
      ISSUE_HOLD  = 2'd1,
      ISSUE_DRAIN = 2'd2
   } issue_state_t;

endpackage

// File: rtl/trigger_issue_saturating_counter.sv
// rtl/trigger_issue_saturating_counter.sv - saturating event counter for issue statistics
// Ports: clock, reset_n (async active-low), inc_en (count this cycle),
//        count (COUNTER_WIDTH, sticks at all-ones).
module trigger_issue_saturating_counter #(
   parameter int unsigned COUNTER_WIDTH = 32
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     inc_en,
   output logic [COUNTER_WIDTH-1:0] count
);

   logic [COUNTER_WIDTH-1:0] count_q;
   logic [COUNTER_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_en && (count_q != {COUNTER_WIDTH{1'b1}})) begin
         count_d = count_q + COUNTER_WIDTH'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/trigger_issue_stage.sv
// rtl/trigger_issue_stage.sv - registered issue stage with predicate-write interlock
// Ports: clock, reset_n (async active-low), enable, triggered_instruction_valid/index,
//        triggered_predicate_write, triggered_instruction_accepted (comb strobe),
//        issue_valid/issue_index/issue_ready (output handshake), issue_locked,
//        issue_count/stall_count (only with TIA_ISSUE_PERF_COUNTERS_EN).
// Macro: TIA_ISSUE_PERF_COUNTERS_EN enables the saturating performance counters.
module trigger_issue_stage
   import trigger_issue_stage_pkg::*;
#(
   parameter int unsigned INDEX_WIDTH              = TIA_INSTRUCTION_INDEX_WIDTH,
   parameter int unsigned PREDICATE_UPDATE_LATENCY = TIA_PREDICATE_UPDATE_LATENCY,
   parameter int unsigned COUNTER_WIDTH            = 32
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     triggered_instruction_valid,
   input  logic [INDEX_WIDTH-1:0]   triggered_instruction_index,
   input  logic                     triggered_predicate_write,
   output logic                     triggered_instruction_accepted,
   output logic                     issue_valid,
   output logic [INDEX_WIDTH-1:0]   issue_index,
   input  logic                     issue_ready,
`ifdef TIA_ISSUE_PERF_COUNTERS_EN
   output logic [COUNTER_WIDTH-1:0] issue_count,
   output logic [COUNTER_WIDTH-1:0] stall_count,
`endif
   output logic                     issue_locked
);

   localparam logic [TIA_DRAIN_COUNT_WIDTH-1:0] DRAIN_LOAD =
      TIA_DRAIN_COUNT_WIDTH'(PREDICATE_UPDATE_LATENCY);

   issue_state_t                     state_q, state_d;
   logic [TIA_DRAIN_COUNT_WIDTH-1:0] drain_count_q, drain_count_d;
   logic                             issue_valid_q, issue_valid_d;
   logic [INDEX_WIDTH-1:0]           issue_index_q, issue_index_d;
   logic                             issue_locked_q, issue_locked_d;

   logic accept;
   logic handshake;

   // reset_n gates the strobe so the channel logic never sees a take during reset.
   assign accept = reset_n & enable & triggered_instruction_valid & ~issue_locked_q &
                   (~issue_valid_q | issue_ready);
   assign handshake = issue_valid_q & issue_ready;

   always_comb begin
      issue_valid_d = issue_valid_q;
      issue_index_d = issue_index_q;
      if (accept) begin
         issue_valid_d = 1'b1;
         issue_index_d = triggered_instruction_index;
      end else if (handshake) begin
         issue_valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d       = state_q;
      drain_count_d = drain_count_q;
      case (state_q)
         ISSUE_IDLE: begin
            if (accept && triggered_predicate_write) begin
               state_d = ISSUE_HOLD;
            end
         end
         ISSUE_HOLD: begin
            // The predicate writer is the only thing in the output register here.
            if (handshake) begin
               if (PREDICATE_UPDATE_LATENCY == 0) begin
                  state_d = ISSUE_IDLE;
               end else begin
                  state_d       = ISSUE_DRAIN;
                  drain_count_d = DRAIN_LOAD;
               end
            end
         end
         ISSUE_DRAIN: begin
            if (drain_count_q != '0) begin
               drain_count_d = drain_count_q - TIA_DRAIN_COUNT_WIDTH'(1);
            end
            if (drain_count_q <= TIA_DRAIN_COUNT_WIDTH'(1)) begin
               state_d = ISSUE_IDLE;
            end
         end
         default: begin
            state_d       = ISSUE_IDLE;
            drain_count_d = '0;
         end
      endcase
      issue_locked_d = (state_d != ISSUE_IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ISSUE_IDLE;
         drain_count_q  <= '0;
         issue_valid_q  <= 1'b0;
         issue_index_q  <= '0;
         issue_locked_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         drain_count_q  <= drain_count_d;
         issue_valid_q  <= issue_valid_d;
         issue_index_q  <= issue_index_d;
         issue_locked_q <= issue_locked_d;
      end
   end

   assign triggered_instruction_accepted = accept;
   assign issue_valid                    = issue_valid_q;
   assign issue_index                    = issue_index_q;
   assign issue_locked                   = issue_locked_q;

`ifdef TIA_ISSUE_PERF_COUNTERS_EN
   logic stall_event;
   assign stall_event = enable & triggered_instruction_valid & ~accept;

   trigger_issue_saturating_counter #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
   ) u_issue_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .inc_en  (handshake),
      .count   (issue_count)
   );

   trigger_issue_saturating_counter #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
   ) u_stall_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .inc_en  (stall_event),
      .count   (stall_count)
   );
`endif

endmodule

// File: tb/tb_trigger_issue_stage.sv
// tb/tb_trigger_issue_stage.sv - scoreboard bench for trigger_issue_stage
module tb_trigger_issue_stage;
   import trigger_issue_stage_pkg::*;

   localparam int IW = TIA_INSTRUCTION_INDEX_WIDTH;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          enable, tv, tpw, rdy;
   logic [IW-1:0] tidx;

   logic          acc_a, vld_a, lock_a;
   logic [IW-1:0] idx_a;
   logic          acc_b, vld_b, lock_b;
   logic [IW-1:0] idx_b;
`ifdef TIA_ISSUE_PERF_COUNTERS_EN
   logic [CW-1:0] icnt_a, scnt_a, icnt_b, scnt_b;
`endif

   always #5 clock = ~clock;

   // u_a: default latency 2; u_b: latency 0. Both share stimulus, sel picks the checked one.
   trigger_issue_stage #(.PREDICATE_UPDATE_LATENCY(2), .COUNTER_WIDTH(CW)) u_a (
      .clock                          (clock),
      .reset_n                        (reset_n),
      .enable                         (enable),
      .triggered_instruction_valid    (tv),
      .triggered_instruction_index    (tidx),
      .triggered_predicate_write      (tpw),
      .triggered_instruction_accepted (acc_a),
      .issue_valid                    (vld_a),
      .issue_index                    (idx_a),
      .issue_ready                    (rdy),
`ifdef TIA_ISSUE_PERF_COUNTERS_EN
      .issue_count                    (icnt_a),
      .stall_count                    (scnt_a),
`endif
      .issue_locked                   (lock_a)
   );

   trigger_issue_stage #(.PREDICATE_UPDATE_LATENCY(0), .COUNTER_WIDTH(CW)) u_b (
      .clock                          (clock),
      .reset_n                        (reset_n),
      .enable                         (enable),
      .triggered_instruction_valid    (tv),
      .triggered_instruction_index    (tidx),
      .triggered_predicate_write      (tpw),
      .triggered_instruction_accepted (acc_b),
      .issue_valid                    (vld_b),
      .issue_index                    (idx_b),
      .issue_ready                    (rdy),
`ifdef TIA_ISSUE_PERF_COUNTERS_EN
      .issue_count                    (icnt_b),
      .stall_count                    (scnt_b),
`endif
      .issue_locked                   (lock_b)
   );

   typedef struct {
      logic acc;
      logic lock;
      logic vld;
   } exp_t;

   exp_t          exp_q[$];
   logic [IW-1:0] idx_q[$];
   int            applied = 0;
   int            miscompares = 0;
   logic          sel = 1'b0;

   logic          m_acc, m_vld, m_lock;
   logic [IW-1:0] m_idx;
   assign m_acc  = sel ? acc_b  : acc_a;
   assign m_vld  = sel ? vld_b  : vld_a;
   assign m_lock = sel ? lock_b : lock_a;
   assign m_idx  = sel ? idx_b  : idx_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      applied++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // One clock cycle of stimulus plus its expected per-cycle response.
   task automatic cyc(input logic en, input logic v, input int idx, input logic pw,
                      input logic r, input logic a, input logic l, input logic vl);
      exp_t e;
      @(posedge clock);
      #1;
      enable = en;
      tv     = v;
      tidx   = IW'(idx);
      tpw    = pw;
      rdy    = r;
      e.acc  = a;
      e.lock = l;
      e.vld  = vl;
      exp_q.push_back(e);
      if (a) idx_q.push_back(IW'(idx));
   endtask

   // Asynchronous reset between clock edges; outputs must clear immediately.
   task automatic reset_now();
      reset_n = 1'b0;
      #1;
      check("rst_valid", m_vld, 0);
      check("rst_index", m_idx, 0);
      check("rst_locked", m_lock, 0);
      check("rst_accepted", m_acc, 0);
`ifdef TIA_ISSUE_PERF_COUNTERS_EN
      check("rst_issue_count", icnt_a, 0);
      check("rst_stall_count", scnt_a, 0);
`endif
      tv  = 1'b0;
      rdy = 1'b0;
      idx_q.delete();
      #1;
      reset_n = 1'b1;
   endtask

   // Monitor: per-cycle strobe/lock/valid checks and the index scoreboard on handshakes.
   always @(negedge clock) begin
      exp_t e;
      logic [IW-1:0] want;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("accepted", m_acc, e.acc);
         check("locked", m_lock, e.lock);
         check("issue_valid", m_vld, e.vld);
      end
      if (reset_n && m_vld && rdy) begin
         if (idx_q.size() == 0) begin
            check("unexpected_handshake", 1, 0);
         end else begin
            want = idx_q.pop_front();
            check("issue_index", m_idx, want);
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;
      tv      = 1'b0;
      tpw     = 1'b0;
      rdy     = 1'b0;
      tidx    = '0;
      #12;
      check("init_valid", vld_a, 0);
      check("init_index", idx_a, 0);
      check("init_locked", lock_a, 0);
      check("init_accepted", acc_a, 0);
      #1;
      reset_n = 1'b1;

      // streaming 3,4,5
      cyc(1, 1, 3, 0, 1, 1, 0, 0);
      cyc(1, 1, 4, 0, 1, 1, 0, 1);
      cyc(1, 1, 5, 0, 1, 1, 0, 1);
      cyc(1, 0, 0, 0, 1, 0, 0, 1);
      // back-pressure on index 7
      cyc(1, 1, 7, 0, 1, 1, 0, 0);
      repeat (4) cyc(1, 1, 8, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1, 0, 0, 1);
`ifdef TIA_ISSUE_PERF_COUNTERS_EN
      check("stall_backpressure", scnt_a, 4);
`endif
      // predicate interlock, latency 2
      cyc(1, 1, 2, 1, 1, 1, 0, 0);
      cyc(1, 1, 9, 0, 1, 0, 1, 1);
      cyc(1, 1, 9, 0, 1, 0, 1, 0);
      cyc(1, 1, 9, 0, 1, 0, 1, 0);
      cyc(1, 1, 9, 0, 1, 1, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 0, 1);
      // enable low blocks acceptance but register drains and FSM advances
      cyc(0, 1, 6, 0, 1, 0, 0, 0);
      cyc(1, 1, 6, 1, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0, 1, 0);
      cyc(1, 1, 1, 0, 0, 1, 0, 0);
      cyc(1, 1, 10, 0, 0, 0, 0, 1);
      @(posedge clock);
      #2;
`ifdef TIA_ISSUE_PERF_COUNTERS_EN
      check("issue_count_mid", icnt_a, 7);
      check("stall_count_mid", scnt_a, 8);
`endif
      reset_now();   // held instruction 1 is discarded

      // reset while in DRAIN
      cyc(1, 1, 12, 1, 1, 1, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 1, 1);
      cyc(1, 0, 0, 0, 1, 0, 1, 0);
      @(posedge clock);
      #2;
      reset_now();
      cyc(1, 1, 13, 0, 1, 1, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 0, 1);

      // 20 back-to-back handshakes to saturate the 4-bit counter
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, i + 11, 0, 1, 1, 0, (i == 0) ? 1'b0 : 1'b1);
      end
      cyc(1, 0, 0, 0, 1, 0, 0, 1);
      @(posedge clock);
      #2;
`ifdef TIA_ISSUE_PERF_COUNTERS_EN
      check("issue_count_sat", icnt_a, 15);
      check("stall_count_end", scnt_a, 0);
`endif

      // latency 0 instance: lock spans only the HOLD cycles
      sel = 1'b1;
      reset_now();
      cyc(1, 1, 4, 1, 0, 1, 0, 0);
      repeat (3) cyc(1, 1, 11, 0, 0, 0, 1, 1);
      cyc(1, 1, 11, 0, 1, 0, 1, 1);
      cyc(1, 1, 11, 0, 1, 1, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      #1;
      check("exp_queue_drained", exp_q.size(), 0);
      check("idx_queue_drained", idx_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
